clk_rst_sequencer: RTL



---
 rtl/clk_rst_sequencer_pkg.sv | 42 ++++
 rtl/clk_rst_sequencer_if.sv | 23 ++
 rtl/clk_rst_sequencer_sync_debounce.sv | 58 +++++
 rtl/clk_rst_sequencer.sv | 103 ++++++++++
 4 files changed

// File: rtl/clk_rst_sequencer_pkg.sv
// Shared state encoding, per-state reset-output vectors and sizing helpers
// for the board clock/reset sequencer.
package clk_rst_sequencer_pkg;

  typedef enum logic [2:0] {
    S_MMCM_RST  = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_REL_CORE  = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  // Vectors are {mmcm_rst, core_rst_n, periph_rst_n}
  localparam logic [2:0] OUT_MMCM_RST = 3'b100;
  localparam logic [2:0] OUT_WAIT     = 3'b000;
  localparam logic [2:0] OUT_REL_CORE = 3'b010;
  localparam logic [2:0] OUT_RUN      = 3'b011;
  localparam logic [2:0] OUT_FAULT    = 3'b100;

  function automatic logic [2:0] state_outs(state_t s);
    case (s)
      S_MMCM_RST:  return OUT_MMCM_RST;
      S_WAIT_LOCK: return OUT_WAIT;
      S_STABLE:    return OUT_WAIT;
      S_REL_CORE:  return OUT_REL_CORE;
      S_RUN:       return OUT_RUN;
      S_FAULT:     return OUT_FAULT;
      default:     return OUT_MMCM_RST;
    endcase
  endfunction

  function automatic int max4(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/clk_rst_sequencer_if.sv
// Pin-side bundle of the sequencer: async board inputs in, MMCM/core/peripheral
// resets and status out.
interface clk_rst_sequencer_if;
  logic       btn_n;
  logic       ext_rst;
  logic       mmcm_locked;
  logic       mmcm_rst;
  logic       core_rst_n;
  logic       periph_rst_n;
  logic [2:0] state_o;
  logic [1:0] retry_cnt;
  logic       fault;

  modport master (
    input  btn_n, ext_rst, mmcm_locked,
    output mmcm_rst, core_rst_n, periph_rst_n, state_o, retry_cnt, fault
  );

  modport slave (
    output btn_n, ext_rst, mmcm_locked,
    input  mmcm_rst, core_rst_n, periph_rst_n, state_o, retry_cnt, fault
  );
endinterface

// File: rtl/clk_rst_sequencer_sync_debounce.sv
// Multi-flop synchronizer with an optional counter debouncer; DEBOUNCE_CYCLES = 0
// gives a plain synchronizer with press_evt tied low.
module sync_debounce #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 0,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout_s,
  output logic press_evt
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= {SYNC_STAGES{RST_VAL}};
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], din};
  end

  assign dout_s = r_sync[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nodb
      assign press_evt = 1'b0;
    end else begin : g_db
      localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      logic [DW-1:0] r_cnt;
      logic          r_stable;
      logic          r_evt;

      // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples;
      // only the flip to low (a press) raises the event, so holding fires once.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt    <= '0;
          r_stable <= 1'b1;
          r_evt    <= 1'b0;
        end else begin
          r_evt <= 1'b0;
          if (dout_s == r_stable) begin
            r_cnt <= '0;
          end else if (r_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            r_cnt    <= '0;
            r_stable <= dout_s;
            r_evt    <= ~dout_s;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign press_evt = r_evt;
    end
  endgenerate

endmodule

// File: rtl/clk_rst_sequencer.sv
// Board bring-up sequencer: pulses MMCM reset, qualifies LOCKED with timeout and
// retry, then releases core and peripheral resets in stages.
module clk_rst_sequencer
  import clk_rst_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int MMCM_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT    = 65536,
  parameter int STABLE_CYCLES   = 1024,
  parameter int STAGE_GAP       = 256,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_RETRY       = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  clk_rst_sequencer_if.master bus
);

  localparam int CNT_MAX = max4(MMCM_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, STAGE_GAP);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic w_btn_s, w_press, w_ext_s, w_ext_evt, w_lock_s, w_lock_evt, w_restart;

  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1))
    u_btn  (.clk(clk), .rst_n(rst_n), .din(bus.btn_n), .dout_s(w_btn_s), .press_evt(w_press));
  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(0), .RST_VAL(1'b0))
    u_ext  (.clk(clk), .rst_n(rst_n), .din(bus.ext_rst), .dout_s(w_ext_s), .press_evt(w_ext_evt));
  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(0), .RST_VAL(1'b0))
    u_lock (.clk(clk), .rst_n(rst_n), .din(bus.mmcm_locked), .dout_s(w_lock_s), .press_evt(w_lock_evt));

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_retry, w_retry_nxt, w_retry_inc;
  logic [2:0]       r_out, w_out_nxt;
  logic             r_fault, w_fault_nxt;

  assign w_restart   = w_ext_s | w_press;
  assign w_retry_inc = (int'(r_retry) >= MAX_RETRY) ? r_retry : r_retry + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_MMCM_RST;
      r_cnt   <= '0;
      r_retry <= '0;
      r_out   <= OUT_MMCM_RST;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_retry <= w_retry_nxt;
      r_out   <= w_out_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    if (w_restart) begin
      w_state_nxt = S_MMCM_RST;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        S_MMCM_RST:
          if (r_cnt == CNT_W'(MMCM_RST_CYCLES - 1)) w_state_nxt = S_WAIT_LOCK;
        S_WAIT_LOCK:
          if (w_lock_s) begin
            w_state_nxt = S_STABLE;
          end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
            w_retry_nxt = w_retry_inc;
            w_state_nxt = (int'(w_retry_inc) >= MAX_RETRY) ? S_FAULT : S_MMCM_RST;
          end
        S_STABLE:
          if (!w_lock_s)                                w_state_nxt = S_WAIT_LOCK;
          else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) w_state_nxt = S_REL_CORE;
        S_REL_CORE:
          if (r_cnt == CNT_W'(STAGE_GAP - 1)) w_state_nxt = S_RUN;
        S_RUN:
          if (!w_lock_s) w_state_nxt = S_MMCM_RST;
        S_FAULT:     w_state_nxt = S_FAULT;
        default:     w_state_nxt = S_MMCM_RST;
      endcase
      if (w_state_nxt == S_RUN && r_state != S_RUN) w_retry_nxt = '0;
    end
    // One shared counter: restarts on any state change, idles where nothing is timed
    if (w_restart || w_state_nxt != r_state)        w_cnt_nxt = '0;
    else if (r_state == S_RUN || r_state == S_FAULT) w_cnt_nxt = r_cnt;
    else                                             w_cnt_nxt = r_cnt + 1'b1;
  end

  always_comb begin
    w_out_nxt   = state_outs(w_state_nxt);
    w_fault_nxt = (w_state_nxt == S_FAULT);
  end

  assign bus.mmcm_rst     = r_out[2];
  assign bus.core_rst_n   = r_out[1];
  assign bus.periph_rst_n = r_out[0];
  assign bus.state_o      = r_state;
  assign bus.retry_cnt    = r_retry;
  assign bus.fault        = r_fault;

endmodule
